// File: rtl/l2_responder_pkg.sv
// Shared types and helpers for the L2 line responder: FSM state encoding,
// default geometry and line alignment.
package l2_responder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam int S_OFFSET = 5;
    localparam int S_LINE   = 256;
    localparam int S_BEAT   = 64;
    localparam int BEATS    = S_LINE / S_BEAT;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic logic [31:0] line_align(input logic [31:0] a, input int unsigned off);
        return a & ~((32'h1 << off) - 32'h1);
    endfunction

endpackage

// File: rtl/l2_line_responder_line_beat_buffer.sv
// Line register with beat-granular deserialize/serialize and the beat counter
// that walks it; the counter wraps to zero on the last beat.
module line_beat_buffer #(
    parameter int s_line = 256,
    parameter int s_beat = 64,
    parameter int beats  = 4,
    parameter int cnt_w  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [s_line-1:0] load_line,
    input  logic              beat_we,
    input  logic [s_beat-1:0] beat_data,
    input  logic              advance,
    output logic [s_line-1:0] line,
    output logic [s_beat-1:0] beat_out,
    output logic              last
);

    logic [beats-1:0][s_beat-1:0] data_q;
    logic [cnt_w-1:0]             cnt;

    assign line     = data_q;
    assign beat_out = data_q[cnt];
    assign last     = (cnt == cnt_w'(beats - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_line;
        end else if (beat_we) begin
            data_q[cnt] <= beat_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/l2_line_responder.sv
// L2-side line responder: turns one line read/write into a fixed beat burst.
// Define L2_RESPONDER_LINE_BUF_EN to add a one-entry read line buffer.
module l2_line_responder
    import l2_responder_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [31:0]       l2_address,
    input  logic [s_line-1:0] l2_wdata,
    input  logic              l2_stall,
    output logic              l2_resp,
    output logic [s_line-1:0] l2_rdata,
    output logic              l2_ready,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_beat-1:0] pmem_wdata,
    input  logic [s_beat-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int NBEATS = s_line / s_beat;
    localparam int NCNT_W = cnt_width(NBEATS);

    state_t            state, next;
    logic [31:0]       addr;
    logic [31:0]       aligned;
    logic              load, beat_we, advance, last;
    logic [s_line-1:0] load_line, line;

    assign aligned = line_align(l2_address, s_offset);

`ifdef L2_RESPONDER_LINE_BUF_EN
    logic                         ent_valid;
    logic [31:0]                  ent_tag;
    logic [s_line-1:0]            ent_data;
    logic                         hit;
    logic [NBEATS-1:0][s_beat-1:0] fill;

    assign hit = ent_valid && (ent_tag == aligned);

    // The final beat is still on the bus when the entry captures the line.
    always_comb begin
        fill = line;
        fill[NBEATS-1] = pmem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= 1'b0;
            ent_tag   <= '0;
            ent_data  <= '0;
        end else if (state == RD_BURST && pmem_resp && last) begin
            ent_valid <= 1'b1;
            ent_tag   <= addr;
            ent_data  <= fill;
        end else if (state == IDLE && l2_write && hit) begin
            ent_data  <= l2_wdata;
        end
    end
`endif

    line_beat_buffer #(
        .s_line (s_line),
        .s_beat (s_beat),
        .beats  (NBEATS),
        .cnt_w  (NCNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_line (load_line),
        .beat_we   (beat_we),
        .beat_data (pmem_rdata),
        .advance   (advance),
        .line      (line),
        .beat_out  (pmem_wdata),
        .last      (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= next;
            if (state == IDLE && (l2_read || l2_write))
                addr <= aligned;
        end
    end

    always_comb begin
        next       = state;
        load       = 1'b0;
        load_line  = l2_wdata;
        beat_we    = 1'b0;
        advance    = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        l2_resp    = 1'b0;
        unique case (state)
            IDLE: begin
                if (l2_write) begin
                    next = WR_BURST;
                    load = 1'b1;
                end else if (l2_read) begin
`ifdef L2_RESPONDER_LINE_BUF_EN
                    if (hit) begin
                        next      = RESP;
                        load      = 1'b1;
                        load_line = ent_data;
                    end else
`endif
                    next = RD_BURST;
                end
            end
            RD_BURST: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    beat_we = 1'b1;
                    advance = 1'b1;
                    if (last) next = RESP;
                end
            end
            WR_BURST: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    advance = 1'b1;
                    if (last) next = RESP;
                end
            end
            RESP: begin
                l2_resp = 1'b1;
                if (!l2_stall) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    assign l2_ready     = (state == IDLE) || (state == RESP && !l2_stall);
    assign pmem_address = addr;
    assign l2_rdata     = line;

endmodule

// File: doc/l2_line_responder.md
Name: l2_line_responder

Overview:
- Responder end of the line-granular L2 request interface.
- Accepts one line read or write at a time from the cache arbiter's L2-side port: l2_read/l2_write/l2_address/l2_wdata in; l2_resp/l2_rdata/l2_ready out; l2_stall in.
- Serves each request with a fixed-length burst on the physical-memory beat interface.
- Holds a completed response stable while upstream stalls.

Parameters:
- s_offset, 5, byte-offset bits per line.
- s_line, 256, line width in bits (8*2**s_offset).
- s_beat, 64, physical-memory beat width in bits; s_line must be a multiple of s_beat.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- l2_read  in  1  line read request.
- l2_write  in  1  line write request.
- l2_address  in  32  request byte address.
- l2_wdata  in  s_line  write line.
- l2_stall  in  1  upstream cannot consume response this cycle.
- l2_resp  out  1  request complete.
- l2_rdata  out  s_line  read line.
- l2_ready  out  1  responder can accept a new request next cycle.
- pmem_read  out  1  burst read active.
- pmem_write  out  1  burst write active.
- pmem_address  out  32  line-aligned burst address.
- pmem_wdata  out  s_beat  current write beat.
- pmem_rdata  in  s_beat  current read beat.
- pmem_resp  in  1  beat accepted/valid this cycle.

Behaviour:
- Constants: BEATS = s_line/s_beat (4 at defaults); beat counter width = $clog2(BEATS).
- Reset (async, any state):
  - state = IDLE; beat counter = 0.
  - l2_resp = 0, pmem_read = 0, pmem_write = 0.
  - l2_ready = 1, pmem_address = 0, l2_rdata = 0.
- States: IDLE, RD_BURST, WR_BURST, RESP.
- IDLE:
  - On l2_write: latch address with low s_offset bits zeroed, latch l2_wdata, go to WR_BURST.
  - Else on l2_read: latch aligned address, go to RD_BURST.
  - If l2_read and l2_write are both high, the write wins; the read is dropped.
- RD_BURST:
  - pmem_read = 1 and pmem_address = latched address, held constant for the whole burst.
  - Each cycle with pmem_resp: store pmem_rdata into slice [cnt*s_beat +: s_beat] of the line buffer, then cnt++.
  - On the pmem_resp with cnt == BEATS-1: cnt wraps to 0, go to RESP.
- WR_BURST:
  - pmem_write = 1; pmem_wdata = latched line slice [cnt*s_beat +: s_beat].
  - Each pmem_resp advances cnt; on the last beat, go to RESP.
- RESP:
  - l2_resp = 1; l2_rdata = line buffer (the last read line; don't-care after a write).
  - If l2_stall: stay in RESP, keeping l2_resp and l2_rdata stable.
  - Else: go to IDLE next cycle.
  - New requests are never sampled in RESP.
- l2_ready = (state == IDLE) | (state == RESP & ~l2_stall).
- Request inputs are ignored outside IDLE; the requester holds them until l2_resp.
- Minimum latency, request to l2_resp: 1 + BEATS cycles (with pmem_resp every cycle).
- pmem_resp outside a burst is ignored.
- Reset mid-burst: the pmem strobe drops immediately; the partial line is discarded.

Optional Feature:
- Macro: L2_RESPONDER_LINE_BUF_EN.
- Defined:
  - Adds a one-entry read line buffer (valid bit plus tag = aligned address).
  - An IDLE read whose address matches a valid entry goes straight to RESP (latency 1, no pmem activity).
  - A completed read burst fills the entry and sets valid.
  - A write to a matching address updates the entry with l2_wdata; the write burst still occurs.
  - Reset clears valid.
- Undefined: no entry exists and every read bursts.

Decomposition:
- Package l2_responder_pkg:
  - state enum (IDLE, RD_BURST, WR_BURST, RESP).
  - BEATS and beat-counter-width localparams derived from s_line/s_beat.
  - Line-alignment mask function.
- Sub-module line_beat_buffer:
  - s_line register with beat-indexed write (deserialize) and beat-indexed read mux (serialize).
  - Owns the beat counter with wrap flag.
- The top level holds the FSM and the optional buffer.

Test Plan:
1. l2_read @0x0000_1234, pmem returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> pmem_address = 0x0000_1220; l2_resp high for 1 cycle, 5 cycles after the request; l2_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
2. l2_write @0x0000_0040 with a line of ascending bytes -> pmem_wdata beats in order 0x0706050403020100, then the next 8 bytes ..., each held until pmem_resp; l2_resp after the 4th beat.
3. Read completes with l2_stall high for 3 cycles -> l2_resp and l2_rdata stable for 4 cycles; l2_ready low during the stall, high once the stall drops; return to IDLE.
4. l2_read and l2_write asserted together -> only pmem_write bursts; pmem_read never asserts.
5. rst pulsed after 2 beats of a read -> pmem_read falls in the same cycle, state = IDLE; a following read fetches all 4 beats fresh.
6. With L2_RESPONDER_LINE_BUF_EN: two reads to 0x100 -> the second has l2_resp 1 cycle after the request with no pmem_read. Then a write to 0x100 followed by a read of 0x100 -> read returns the written data without a burst.
